// File: rtl/async_clk_seq_gen.sv
// Multi-node divided clock generator with a reset/send/cooldown run sequencer.
// Node clocks free-run from PHASES offsets; the sequencer paces one test run per start.
module async_clk_seq_gen #(
    parameter int                        NUM_NODES   = 9,
    parameter int                        PW          = 8,
    parameter logic [NUM_NODES*PW-1:0]   PERIODS     = {NUM_NODES{PW'(32'd4)}},
    parameter logic [NUM_NODES*PW-1:0]   PHASES      = '0,
    parameter int                        RST_CYCLES  = 20,
    parameter int                        SEND_CYCLES = 10000,
    parameter int                        COOL_CYCLES = 20000,
    parameter int                        CW          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_NODES-1:0] stall,
    output logic [NUM_NODES-1:0] node_clk,
    output logic                 node_rst,
    output logic                 send,
    output logic                 done,
    output logic [1:0]           state
);

    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SEND_LOAD = CW'(SEND_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOL_CYCLES - 1);

    for (genvar i = 0; i < NUM_NODES; i++) begin : g_div
        localparam logic [PW-1:0] PER  = PERIODS[i*PW +: PW];
        localparam logic [PW-1:0] PH   = PHASES[i*PW +: PW];
        localparam logic [PW-1:0] HALF = PER >> 1;
        localparam logic [PW-1:0] LAST = PER - PW'(32'd1);

        logic [PW-1:0] cnt_r;
        logic          clk_r;

        // Divider: output is high for the first half of each period, frozen by stall.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_r <= PH;
                clk_r <= 1'b0;
            end else if (!stall[i]) begin
                cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + PW'(32'd1);
                clk_r <= (cnt_r < HALF);
            end else begin
                cnt_r <= cnt_r;
                clk_r <= clk_r;
            end
        end

        assign node_clk[i] = clk_r;
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_SEND = 3'd2,
        S_COOL = 3'd3,
        S_DONE = 3'd4
    } seq_t;

    seq_t          state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          node_rst_s, send_s, done_s;
    logic [1:0]    state_code_s;

    // Next-state logic; each timed state counts its load value down to zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_s = S_RST;
                        cnt_s   = RST_LOAD;
                    end else begin
                        state_s = state_r;
                    end
                end
                S_RST: begin
                    if (cnt_r == '0) begin
                        state_s = S_SEND;
                        cnt_s   = SEND_LOAD;
                    end else begin
                        cnt_s = cnt_r - CW'(32'd1);
                    end
                end
                S_SEND: begin
                    if (cnt_r == '0) begin
                        state_s = S_COOL;
                        cnt_s   = COOL_LOAD;
                    end else begin
                        cnt_s = cnt_r - CW'(32'd1);
                    end
                end
                S_COOL: begin
                    if (cnt_r == '0) begin
                        state_s = S_DONE;
                    end else begin
                        cnt_s = cnt_r - CW'(32'd1);
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Output decode of the next state, so registered outputs track the state register.
    always_comb begin
        node_rst_s   = (state_s == S_IDLE) || (state_s == S_RST);
        send_s       = (state_s == S_SEND);
        done_s       = (state_s == S_DONE);
        state_code_s = (state_s == S_DONE) ? 2'd0 : state_s[1:0];
    end

    // Sequencer state, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            node_rst <= 1'b1;
            send     <= 1'b0;
            done     <= 1'b0;
            state    <= 2'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            node_rst <= node_rst_s;
            send     <= send_s;
            done     <= done_s;
            state    <= state_code_s;
        end
    end

endmodule

// File: tb/tb_async_clk_seq_gen.sv
// Randomized bench for async_clk_seq_gen: a timeline-based reference model feeds
// an expected-value queue that a separate monitor drains once per clock edge.
module tb_async_clk_seq_gen;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int R  = 3;
    localparam int S  = 5;
    localparam int C  = 2;
    localparam logic [N*PW-1:0] PER = {8'd3, 8'd5, 8'd6, 8'd4};
    localparam logic [N*PW-1:0] PHS = {8'd0, 8'd1, 8'd2, 8'd0};

    int per_a [N] = '{4, 6, 5, 3};
    int ph_a  [N] = '{0, 2, 1, 0};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] stall = '0;
    logic [N-1:0] node_clk;
    logic         node_rst, send, done;
    logic [1:0]   state;

    typedef struct packed {
        logic [N-1:0] nclk;
        logic         nrst;
        logic         snd;
        logic         dn;
        logic [1:0]   st;
    } exp_t;

    exp_t q[$];
    exp_t actual;
    exp_t rexp;
    int compared   = 0;
    int mismatched = 0;

    int           k [N];
    logic [N-1:0] m_clk;
    int           mode;   // 0 idle, 1 running, 2 done
    int           t;      // edges since the start edge

    async_clk_seq_gen #(
        .NUM_NODES(N), .PW(PW), .PERIODS(PER), .PHASES(PHS),
        .RST_CYCLES(R), .SEND_CYCLES(S), .COOL_CYCLES(C), .CW(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
        .node_clk(node_clk), .node_rst(node_rst), .send(send), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    assign actual = {node_clk, node_rst, send, done, state};

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.nclk = m_clk;
        if (mode == 0) begin
            e.nrst = 1'b1;
        end else if (mode == 2) begin
            e.dn = 1'b1;
        end else if (t < R) begin
            e.nrst = 1'b1;
            e.st   = 2'd1;
        end else if (t < R + S) begin
            e.snd = 1'b1;
            e.st  = 2'd2;
        end else begin
            e.st = 2'd3;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) k[i] = 0;
        m_clk = '0;
        mode  = 0;
        t     = 0;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic a, input logic [N-1:0] st);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!st[i]) begin
                    m_clk[i] = (((ph_a[i] + k[i]) % per_a[i]) < (per_a[i] / 2));
                    k[i]++;
                end
            end
            if (a) begin
                mode = 0;
            end else if (mode != 1 && s) begin
                mode = 1;
                t    = 0;
            end else if (mode == 1) begin
                t++;
                if (t >= R + S + C) mode = 2;
            end
        end
    endtask

    task automatic check(input string name, input exp_t got, input exp_t want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s @%0t: got clk=%b rst=%b send=%b done=%b st=%0d, want clk=%b rst=%b send=%b done=%b st=%0d",
                     name, $time, got.nclk, got.nrst, got.snd, got.dn, got.st,
                     want.nclk, want.nrst, want.snd, want.dn, want.st);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic [N-1:0] st);
        @(negedge clk);
        reset = r;
        start = s;
        abort = a;
        stall = st;
        model_edge(r, s, a, st);
        q.push_back(model_out());
    endtask

    // Monitor: one expected entry per clock edge, compared shortly after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("cycle", actual, e);
            end
        end
    end

    initial begin
        int guard;
        rexp      = '0;
        rexp.nrst = 1'b1;
        model_reset();

        #1 reset = 1'b1;
        #1 check("reset_state", actual, rexp);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0);
        repeat (8) step(1'b0, 1'b0, 1'b0, '0);

        // Stall node 0 for three edges while it is high.
        guard = 0;
        while (!m_clk[0] && guard < 10) begin
            step(1'b0, 1'b0, 1'b0, '0);
            guard++;
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 4'b0001);
        repeat (6) step(1'b0, 1'b0, 1'b0, '0);

        // Full run, DONE hold, then a second run.
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (15) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (14) step(1'b0, 1'b0, 1'b0, '0);

        // Abort during the second SEND cycle.
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (R + 1) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);

        // Start and abort together while DONE.
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (12) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, '0);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);

        // Randomized traffic.
        repeat (400) begin
            logic [N-1:0] st_v;
            st_v = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0), st_v);
        end
        step(1'b0, 1'b0, 1'b1, '0);

        // Asynchronous reset between edges in the middle of COOLDOWN.
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (R + S + 1) step(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1 check("async_reset_cool", actual, rexp);
        model_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, 1'b0, '0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
